// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns a core load/store into a single bus transaction.
// Stalls the core while the bus is busy, then returns the extended load data and a fault code.
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRW,
  input  logic [2:0]  MemRdCtrl,
  input  logic [1:0]  MemWrCtrl,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // state | meaning
  // IDLE  | waiting for a valid access; misaligned ones go straight to DONE
  // BUSY  | bus_req held with latched fields until ack or timeout
  // DONE  | one-cycle completion pulse, fault and rdata valid
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rw_q;
  logic        signed_q;
  logic [1:0]  size_q;

  logic [31:0] rdata_q;
  logic [1:0]  fault_q;

  logic        is_store;
  logic        is_load;
  logic        access_ok;
  logic [1:0]  size_c;
  logic        signed_c;
  logic        misaligned;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_c;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Decode of the incoming request, evaluated only in IDLE.
  always_comb begin
    is_store  = MemRW && (MemWrCtrl != 2'd0);
    is_load   = !MemRW && (MemRdCtrl >= 3'd1) && (MemRdCtrl <= 3'd5);
    access_ok = req_valid && (is_store || is_load);

    size_c   = SZ_BYTE;
    signed_c = 1'b0;
    if (is_store) begin
      case (MemWrCtrl)
        2'd2:    size_c = SZ_HALF;
        2'd3:    size_c = SZ_WORD;
        default: size_c = SZ_BYTE;
      endcase
    end else begin
      case (MemRdCtrl)
        3'd1:    begin size_c = SZ_BYTE; signed_c = 1'b1; end
        3'd2:    begin size_c = SZ_HALF; signed_c = 1'b1; end
        3'd3:    size_c = SZ_WORD;
        3'd5:    size_c = SZ_HALF;
        default: size_c = SZ_BYTE;
      endcase
    end

    misaligned = ((size_c == SZ_HALF) && addr[0]) ||
                 ((size_c == SZ_WORD) && (addr[1:0] != 2'b00));
  end

  // Bus-side lane steering; enables follow the access size for loads and stores alike.
  always_comb begin
    case (size_q)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
      end
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = bus_rdata[7:0];
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      default: lane_byte = bus_rdata[31:24];
    endcase
    lane_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (size_q)
      SZ_BYTE: load_c = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
      SZ_HALF: load_c = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
      default: load_c = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rw_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      rdata_q  <= 32'd0;
      fault_q  <= FAULT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (access_ok) begin
            if (misaligned) begin
              state   <= DONE;
              fault_q <= FAULT_ALIGN;
              rdata_q <= 32'd0;
            end else begin
              state    <= BUSY;
              wait_cnt <= WAIT_LOAD;
              addr_q   <= addr;
              wdata_q  <= wdata;
              rw_q     <= MemRW;
              signed_q <= signed_c;
              size_q   <= size_c;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state   <= DONE;
            fault_q <= FAULT_NONE;
            rdata_q <= rw_q ? 32'd0 : load_c;
          end else if (wait_cnt == 16'd0) begin
            state   <= DONE;
            fault_q <= FAULT_TIMEOUT;
            rdata_q <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall     = ((state == IDLE) && access_ok) || (state == BUSY);
  assign done      = (state == DONE);
  assign rdata     = rdata_q;
  assign fault     = fault_q;
  assign bus_req   = (state == BUSY);
  assign bus_we    = bus_req && rw_q;
  assign bus_be    = bus_req ? be_c : 4'b0000;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = wdata_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus and completion
// records, a negedge monitor compares whatever the DUT presents.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRW;
  logic [2:0]  MemRdCtrl;
  logic [1:0]  MemWrCtrl;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .addr(addr), .wdata(wdata),
    .MemRW(MemRW), .MemRdCtrl(MemRdCtrl), .MemWrCtrl(MemWrCtrl),
    .stall(stall), .done(done), .rdata(rdata), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  fault;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  prev_req = 1'b0;

  // Monitor: bus fields are compared on every request cycle (stability), popped when bus_req falls.
  always @(negedge clk) begin
    if (bus_req) begin
      total++;
      if (bus_q.size() == 0) begin
        bad++;
        $display("FAIL bus_unexpected: got we=%0b be=%b addr=%h, required no bus_req", bus_we, bus_be, bus_addr);
      end else if ({bus_we, bus_be, bus_addr, bus_wdata} !== bus_q[0]) begin
        bad++;
        $display("FAIL bus_fields: got we=%0b be=%b addr=%h wdata=%h, required we=%0b be=%b addr=%h wdata=%h",
                 bus_we, bus_be, bus_addr, bus_wdata,
                 bus_q[0].we, bus_q[0].be, bus_q[0].addr, bus_q[0].wdata);
      end
    end else if (prev_req && bus_q.size() > 0) begin
      void'(bus_q.pop_front());
    end
    prev_req = bus_req;

    if (done) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got done=1 rdata=%h fault=%b, required done=0", rdata, fault);
      end else begin
        if ({rdata, fault} !== done_q[0]) begin
          bad++;
          $display("FAIL done_result: got rdata=%h fault=%b, required rdata=%h fault=%b",
                   rdata, fault, done_q[0].rdata, done_q[0].fault);
        end
        void'(done_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; addr = 32'd0; wdata = 32'd0; MemRW = 1'b0;
    MemRdCtrl = 3'd0; MemWrCtrl = 2'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
  endtask

  // ack_after: index of the BUSY cycle that gets bus_ack (-1 = never).
  task automatic access(input logic rw, input logic [2:0] rc, input logic [1:0] wc,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_after, input logic [31:0] brd,
                        input int exp_stall, input int exp_busy);
    int n = 0;
    int nstall = 0;
    int nbusy = 0;
    req_valid = 1'b1; MemRW = rw; MemRdCtrl = rc; MemWrCtrl = wc; addr = a; wdata = wd;
    #1;
    while (!done && n < 100) begin
      if (stall) nstall++;
      if (bus_req) begin
        bus_ack   = (nbusy == ack_after);
        bus_rdata = brd;
        nbusy++;
      end else begin
        bus_ack = 1'b0;
      end
      @(posedge clk); #2;
      n++;
    end
    bus_ack = 1'b0;
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL access_timeout: got no done within 100 cycles, required done");
    end
    chk("stall_cycles", 32'(nstall), 32'(exp_stall));
    chk("bus_cycles", 32'(nbusy), 32'(exp_busy));
    req_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    bus_t b;
    b.we = we; b.be = be; b.addr = a; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic push_done(input logic [31:0] rd, input logic [1:0] f);
    done_t d;
    d.rdata = rd; d.fault = f;
    done_q.push_back(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // LB 0x103, ack in second BUSY cycle
    push_bus(1'b0, 4'b1000, 32'h100, 32'h0);
    push_done(32'hFFFFFF80, 2'b00);
    access(1'b0, 3'd1, 2'd0, 32'h103, 32'h0, 1, 32'h80AABBCC, 3, 2);

    // Illegal load type: nothing happens, rdata held
    req_valid = 1'b1; MemRW = 1'b0; MemRdCtrl = 3'd7; addr = 32'h50;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bad_type_stall", 32'(stall), 32'd0);
      chk("bad_type_bus_req", 32'(bus_req), 32'd0);
      @(posedge clk); #2;
    end
    chk("rdata_hold", rdata, 32'hFFFFFF80);
    idle_inputs();

    // Stray ack while idle
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #2 bus_ack = 1'b0;
    chk("stray_ack_done", 32'(done), 32'd0);
    chk("stray_ack_rdata", rdata, 32'hFFFFFF80);

    // SH 0x202, ack in first BUSY cycle (minimum latency)
    push_bus(1'b1, 4'b1100, 32'h200, 32'hABCDABCD);
    push_done(32'h0, 2'b00);
    access(1'b1, 3'd0, 2'd2, 32'h202, 32'h1234ABCD, 0, 32'h0, 2, 1);

    // LW 0x006 misaligned
    push_done(32'h0, 2'b01);
    access(1'b0, 3'd3, 2'd0, 32'h006, 32'h0, 0, 32'h0, 1, 0);

    push_bus(1'b0, 4'b1111, 32'h20, 32'h0);
    push_done(32'hDEADBEEF, 2'b00);
    access(1'b0, 3'd3, 2'd0, 32'h20, 32'h0, 0, 32'hDEADBEEF, 2, 1);

    // LHU 0x010 never acked, TIMEOUT=4
    push_bus(1'b0, 4'b0011, 32'h10, 32'h0);
    push_done(32'h0, 2'b10);
    access(1'b0, 3'd5, 2'd0, 32'h10, 32'h0, -1, 32'hFFFFFFFF, 5, 4);

    push_bus(1'b0, 4'b1100, 32'h10, 32'h0);
    push_done(32'hFFFF8001, 2'b00);
    access(1'b0, 3'd2, 2'd0, 32'h12, 32'h0, 0, 32'h80017FFF, 2, 1);

    push_bus(1'b0, 4'b0010, 32'h0, 32'h0);
    push_done(32'h0000009A, 2'b00);
    access(1'b0, 3'd4, 2'd0, 32'h1, 32'h0, 0, 32'h00009A00, 2, 1);

    push_bus(1'b0, 4'b1100, 32'h0, 32'h0);
    push_done(32'h0000F00D, 2'b00);
    access(1'b0, 3'd5, 2'd0, 32'h2, 32'h0, 0, 32'hF00D1234, 2, 1);

    push_bus(1'b1, 4'b0100, 32'h0, 32'h55555555);
    push_done(32'h0, 2'b00);
    access(1'b1, 3'd0, 2'd1, 32'h2, 32'h00000055, 0, 32'h0, 2, 1);

    push_done(32'h0, 2'b01);
    access(1'b1, 3'd0, 2'd2, 32'h3, 32'hFFFF0000, 0, 32'h0, 1, 0);

    push_bus(1'b0, 4'b0011, 32'h0, 32'h0);
    push_done(32'h00007FFF, 2'b00);
    access(1'b0, 3'd2, 2'd0, 32'h0, 32'h0, 2, 32'h12347FFF, 4, 3);

    // SW 0x40 with reset in the second BUSY cycle, then a late ack
    push_bus(1'b1, 4'b1111, 32'h40, 32'hCAFEF00D);
    req_valid = 1'b1; MemRW = 1'b1; MemWrCtrl = 2'd3; MemRdCtrl = 3'd0;
    addr = 32'h40; wdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    chk("rst_busy_req1", 32'(bus_req), 32'd1);
    @(posedge clk); #2;
    chk("rst_busy_req2", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("abandon_stall", 32'(stall), 32'd0);
    chk("abandon_bus_req", 32'(bus_req), 32'd0);
    chk("abandon_done", 32'(done), 32'd0);
    chk("abandon_rdata", rdata, 32'd0);
    bus_ack = 1'b1;
    @(posedge clk); #2;
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_done", 32'(done), 32'd0);
      chk("late_ack_bus_req", 32'(bus_req), 32'd0);
      @(posedge clk); #2;
    end

    push_bus(1'b1, 4'b1111, 32'h44, 32'h01020304);
    push_done(32'h0, 2'b00);
    access(1'b1, 3'd0, 2'd3, 32'h44, 32'h01020304, 0, 32'h0, 2, 1);

    repeat (3) @(posedge clk);
    #2;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
